// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: register offsets,
// CTRL/STATUS bit positions and the loader FSM state type.
package ccff_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_LEN     = 3'd3;
  localparam logic [2:0] REG_CLKDIV  = 3'd4;
  localparam logic [2:0] REG_SHIFTED = 3'd5;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;
  localparam int unsigned CTRL_ISOL  = 2;
  localparam int unsigned CTRL_TEST  = 3;
  localparam int unsigned CTRL_IE    = 4;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_FULL    = 2;
  localparam int unsigned ST_EMPTY   = 3;
  localparam int unsigned ST_OVF     = 4;
  localparam int unsigned ST_CNT_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } ccff_state_e;

endpackage

// File: rtl/ccff_loader_if.sv
// Wishbone slave bus bundle for the loader; signal names match the wrapper pins.
interface ccff_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ccff_loader_word_fifo.sv
// Synchronous 32-bit word FIFO with flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ccff_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [31:0]      wdata_i,
  input  logic             pop_i,
  output logic [31:0]      rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Wishbone-controlled loader that resets the fabric configuration chain and
// shifts buffered bitstream words LSB-first into ccff_head on a divided prog_clk.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LEN_W       = 24,
  parameter int unsigned PRST_CYCLES = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  ccff_loader_if.slave        wbs,
  output logic                prog_clk,
  output logic                prog_reset,
  output logic                ccff_head,
  input  logic                ccff_tail,
  output logic                isol_n,
  output logic                test_enable,
  output logic                irq
);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PRST_W = $clog2(PRST_CYCLES + 1);

  ccff_state_e       state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_o_q, dat_o_d;
  logic              isol_q, isol_d, test_q, test_d, ie_q, ie_d;
  logic              done_q, done_d, ovf_q, ovf_d;
  logic [LEN_W-1:0]  len_q, len_d, shifted_q, shifted_d, shifted_inc;
  logic [7:0]        clkdiv_q, clkdiv_d, divcnt_q, divcnt_d;
  logic [31:0]       shreg_q, shreg_d, rdback_q, rdback_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic              have_word_q, have_word_d;
  logic [PRST_W-1:0] prst_cnt_q, prst_cnt_d;

  logic              wb_req, wr_req;
  logic [2:0]        reg_sel;
  logic              wr_ctrl, start_w, abort_w, data_wr;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [31:0]       fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       rd_data;
  logic              unused_ok;

  assign unused_ok = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};

  assign wb_req  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
  assign wr_req  = wb_req & wbs.wbs_we_i;
  assign reg_sel = wbs.wbs_adr_i[4:2];
  assign wr_ctrl = wr_req && (reg_sel == REG_CTRL);
  assign start_w = wr_ctrl & wbs.wbs_dat_i[CTRL_START];
  assign abort_w = wr_ctrl & wbs.wbs_dat_i[CTRL_ABORT];
  assign data_wr = wr_req && (reg_sel == REG_DATA);
  assign shifted_inc = shifted_q + 1'b1;

  ccff_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (abort_w),
    .push_i  (data_wr),
    .wdata_i (wbs.wbs_dat_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL:    rd_data = {27'b0, ie_q, test_q, isol_q, 2'b00};
      REG_STATUS:  rd_data = {16'b0, 8'(fifo_count), 3'b0, ovf_q, fifo_empty,
                              fifo_full, done_q, state_q != S_IDLE};
      REG_DATA:    rd_data = rdback_q;
      REG_LEN:     rd_data = 32'(len_q);
      REG_CLKDIV:  rd_data = {24'b0, clkdiv_q};
      REG_SHIFTED: rd_data = 32'(shifted_q);
      default:     rd_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = wb_req;
    dat_o_d     = (wb_req && !wbs.wbs_we_i) ? rd_data : '0;
    isol_d      = isol_q;
    test_d      = test_q;
    ie_d        = ie_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    len_d       = len_q;
    clkdiv_d    = clkdiv_q;
    shifted_d   = shifted_q;
    divcnt_d    = divcnt_q;
    shreg_d     = shreg_q;
    rdback_d    = rdback_q;
    bitcnt_d    = bitcnt_q;
    have_word_d = have_word_q;
    prst_cnt_d  = prst_cnt_q;
    fifo_pop    = 1'b0;

    if (wr_ctrl) begin
      isol_d = wbs.wbs_dat_i[CTRL_ISOL];
      test_d = wbs.wbs_dat_i[CTRL_TEST];
      ie_d   = wbs.wbs_dat_i[CTRL_IE];
    end
    if (wr_req && reg_sel == REG_STATUS) begin
      if (wbs.wbs_dat_i[ST_DONE]) done_d = 1'b0;
      if (wbs.wbs_dat_i[ST_OVF])  ovf_d  = 1'b0;
    end
    if (wr_req && reg_sel == REG_LEN)    len_d    = wbs.wbs_dat_i[LEN_W-1:0];
    if (wr_req && reg_sel == REG_CLKDIV) clkdiv_d = wbs.wbs_dat_i[7:0];

    case (state_q)
      S_IDLE: begin
        if (start_w && !abort_w) begin
          if (len_q == '0) begin
            state_d = S_DONE;
          end else begin
            shifted_d  = '0;
            prst_cnt_d = '0;
            state_d    = S_PRST;
          end
        end
      end
      S_PRST: begin
        if (prst_cnt_q == PRST_W'(PRST_CYCLES - 1)) state_d = S_LOAD;
        else prst_cnt_d = prst_cnt_q + 1'b1;
      end
      S_LOAD: begin
        divcnt_d = '0;
        if (have_word_q) begin
          state_d = S_LOW;
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shreg_d     = fifo_rdata;
          have_word_d = 1'b1;
          bitcnt_d    = '0;
          state_d     = S_LOW;
        end
      end
      S_LOW: begin
        if (divcnt_q == clkdiv_q) begin
          rdback_d = {ccff_tail, rdback_q[31:1]};
          divcnt_d = '0;
          state_d  = S_HIGH;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (divcnt_q == clkdiv_q) begin
          divcnt_d  = '0;
          shifted_d = shifted_inc;
          shreg_d   = shreg_q >> 1;
          bitcnt_d  = bitcnt_q + 1'b1;
          if (shifted_inc == len_q) begin
            have_word_d = 1'b0;
            state_d     = S_DONE;
          end else if (bitcnt_q == 5'd31) begin
            have_word_d = 1'b0;
            state_d     = S_LOAD;
          end else begin
            state_d = S_LOW;
          end
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Overflow only when the word cannot be absorbed by a same-cycle pop.
    if (data_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;

    if (abort_w) begin
      state_d     = S_IDLE;
      have_word_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      dat_o_q     <= '0;
      isol_q      <= 1'b0;
      test_q      <= 1'b0;
      ie_q        <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      len_q       <= '0;
      clkdiv_q    <= '0;
      shifted_q   <= '0;
      divcnt_q    <= '0;
      shreg_q     <= '0;
      rdback_q    <= '0;
      bitcnt_q    <= '0;
      have_word_q <= 1'b0;
      prst_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
      isol_q      <= isol_d;
      test_q      <= test_d;
      ie_q        <= ie_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      len_q       <= len_d;
      clkdiv_q    <= clkdiv_d;
      shifted_q   <= shifted_d;
      divcnt_q    <= divcnt_d;
      shreg_q     <= shreg_d;
      rdback_q    <= rdback_d;
      bitcnt_q    <= bitcnt_d;
      have_word_q <= have_word_d;
      prst_cnt_q  <= prst_cnt_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_o_q;
  assign prog_clk      = (state_q == S_HIGH);
  assign prog_reset    = (state_q == S_PRST);
  assign ccff_head     = ((state_q == S_LOW) || (state_q == S_HIGH)) & shreg_q[0];
  assign isol_n        = isol_q;
  assign test_enable   = test_q;
  assign irq           = ie_q & (done_q | ovf_q);

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader; the fabric chain is modelled as a 4-stage
// shift register on prog_clk, cleared by prog_reset.
module tb_ccff_loader;
  logic clk = 1'b0;
  logic rst;
  logic prog_clk, prog_reset, ccff_head, ccff_tail, isol_n, test_enable, irq;
  logic [3:0] chain = '0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_DATA = 32'h08;
  localparam logic [31:0] A_LEN = 32'h0C, A_CLKDIV = 32'h10, A_SHIFTED = 32'h14;
  localparam logic [31:0] A_UNMAPPED = 32'h1C, A_UNMAPPED_W = 32'h18;

  always #5 clk = ~clk;

  ccff_loader_if wb();

  ccff_loader #(
    .FIFO_DEPTH  (4),
    .LEN_W       (24),
    .PRST_CYCLES (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (wb),
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .isol_n      (isol_n),
    .test_enable (test_enable),
    .irq         (irq)
  );

  always @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) chain <= '0;
    else            chain <= {chain[2:0], ccff_head};
  end
  assign ccff_tail = chain[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          output logic [31:0] rdat);
    logic ok;
    ok = 1'b0;
    rdat = '0;
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = adr; wb.wbs_dat_i = dat;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) begin
        ok = 1'b1;
        rdat = wb.wbs_dat_o;
        break;
      end
    end
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    if (!ok) check("wb_ack_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_cycle(1'b1, adr, dat, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    wb_cycle(1'b0, adr, 32'h0, dat);
  endtask

  task automatic wait_done();
    logic [31:0] st;
    st = '0;
    for (int i = 0; i < 400; i++) begin
      wb_read(A_STATUS, st);
      if (st[1]) break;
    end
    check("wait_done", {31'b0, st[1]}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  bits;
    int          prst, rises, cyc, first_cyc, last_cyc;
    logic        prev, seen;

    rst = 1'b1;
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'b0, prog_clk, prog_reset, ccff_head, isol_n, test_enable, irq,
                            wb.wbs_ack_o, 1'b0}, 32'h0);
    check("reset_dat_o", wb.wbs_dat_o, 32'h0);
    rst = 1'b0;
    wb_read(A_STATUS, rd);  check("reset_status", rd, 32'h0000_0008);
    wb_read(A_CLKDIV, rd);  check("reset_clkdiv", rd, 32'h0);

    // Basic 8-bit load
    wb_write(A_CLKDIV, 32'h0);
    wb_write(A_LEN, 32'd8);
    wb_write(A_DATA, 32'h0000_00A5);
    wb_write(A_CTRL, 32'h1);
    prst = 0;
    for (int i = 0; i < 40; i++) begin
      if (!prog_reset) break;
      prst++;
      @(posedge clk); #1;
    end
    check("prst_cycles", prst, 32'd16);
    bits = '0; rises = 0; prev = 1'b0; first_cyc = 0; last_cyc = 0;
    for (cyc = 0; cyc < 200 && rises < 8; cyc++) begin
      if (prog_clk && !prev) begin
        bits[rises] = ccff_head;
        if (rises == 0) first_cyc = cyc;
        last_cyc = cyc;
        rises++;
      end
      prev = prog_clk;
      @(posedge clk); #1;
    end
    check("head_seq", {24'b0, bits}, 32'h0000_00A5);
    check("prog_clk_period", last_cyc - first_cyc, 32'd14);
    repeat (3) @(posedge clk);
    #1;
    wb_read(A_STATUS, rd);  check("t1_status", rd, 32'h0000_000A);
    wb_read(A_SHIFTED, rd); check("t1_shifted", rd, 32'd8);
    check("t1_irq_masked", {31'b0, irq}, 32'd0);
    wb_write(A_STATUS, 32'h2);

    // Stall in LOAD when the FIFO runs dry
    wb_write(A_LEN, 32'd40);
    wb_write(A_DATA, 32'h1234_5678);
    wb_write(A_CTRL, 32'h1);
    rd = '0;
    for (int i = 0; i < 300; i++) begin
      wb_read(A_SHIFTED, rd);
      if (rd == 32'd32) break;
    end
    repeat (5) @(posedge clk);
    #1;
    check("stall_prog_clk", {31'b0, prog_clk}, 32'd0);
    wb_read(A_SHIFTED, rd); check("stall_shifted", rd, 32'd32);
    wb_read(A_STATUS, rd);  check("stall_status", rd, 32'h0000_0009);
    wb_write(A_DATA, 32'h3);
    wait_done();
    wb_read(A_SHIFTED, rd); check("t2_shifted", rd, 32'd40);
    wb_read(A_STATUS, rd);  check("t2_status", rd, 32'h0000_000A);
    wb_write(A_STATUS, 32'h2);

    // Loopback through 4-stage chain
    wb_write(A_LEN, 32'd32);
    wb_write(A_DATA, 32'hDEAD_BEEF);
    wb_write(A_CTRL, 32'h1);
    wait_done();
    wb_read(A_DATA, rd);    check("loopback_data", rd, 32'hEADB_EEF0);
    wb_read(A_SHIFTED, rd); check("t3_shifted", rd, 32'd32);
    wb_write(A_STATUS, 32'h2);

    // Overflow
    wb_write(A_CTRL, 32'h10);
    for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'h1000 + i);
    wb_read(A_STATUS, rd);  check("ovf_status", rd, 32'h0000_0414);
    check("ovf_irq", {31'b0, irq}, 32'd1);
    wb_write(A_STATUS, 32'h10);
    wb_read(A_STATUS, rd);  check("ovf_cleared", rd, 32'h0000_0404);
    check("ovf_irq_clear", {31'b0, irq}, 32'd0);

    // Abort mid-shift
    wb_write(A_CLKDIV, 32'd3);
    wb_write(A_LEN, 32'd100);
    wb_write(A_CTRL, 32'h11);
    repeat (40) @(posedge clk);
    #1;
    wb_read(A_STATUS, rd);  check("abort_busy_before", {31'b0, rd[0]}, 32'd1);
    wb_write(A_CTRL, 32'h12);
    check("abort_prog_pins", {30'b0, prog_clk, prog_reset}, 32'd0);
    wb_read(A_STATUS, rd);  check("abort_status", rd, 32'h0000_0008);
    check("abort_irq", {31'b0, irq}, 32'd0);

    // LEN = 0
    wb_write(A_LEN, 32'd0);
    wb_write(A_CTRL, 32'h11);
    seen = prog_clk | prog_reset;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | prog_clk | prog_reset;
    end
    check("len0_no_toggle", {31'b0, seen}, 32'd0);
    wb_read(A_STATUS, rd);  check("len0_status", rd, 32'h0000_000A);
    check("len0_irq", {31'b0, irq}, 32'd1);

    // CTRL pins, register widths, unmapped space
    wb_write(A_CTRL, 32'h0C);
    check("ctrl_pins", {29'b0, isol_n, test_enable, irq}, 32'h6);
    wb_read(A_CTRL, rd);    check("ctrl_read", rd, 32'h0000_000C);
    wb_write(A_CLKDIV, 32'h1FF);
    wb_read(A_CLKDIV, rd);  check("clkdiv_mask", rd, 32'h0000_00FF);
    wb_write(A_UNMAPPED_W, 32'hFFFF_FFFF);
    wb_read(A_UNMAPPED, rd); check("unmapped_read", rd, 32'h0);
    wb_read(A_LEN, rd);     check("unmapped_write_ignored", rd, 32'h0);

    // Reset mid-shift
    wb_write(A_STATUS, 32'h2);
    wb_write(A_CLKDIV, 32'h0);
    wb_write(A_LEN, 32'd32);
    wb_write(A_DATA, 32'hFFFF_FFFF);
    wb_write(A_CTRL, 32'h1C);
    repeat (25) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs", {25'b0, prog_clk, prog_reset, ccff_head, isol_n, test_enable, irq,
                              wb.wbs_ack_o}, 32'h0);
    rst = 1'b0;
    wb_read(A_STATUS, rd);  check("rst_mid_status", rd, 32'h0000_0008);
    wb_read(A_LEN, rd);     check("rst_mid_len", rd, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
